qea_host_loader: RTL and testbench

//  Upstream sequencer for the QEA core: accepts a job command plus valid/ready streams of gate-context

---
 rtl/qea_loader_pkg.sv | 40 ++++
 rtl/qea_rd_skid.sv | 28 ++
 rtl/qea_host_loader.sv | 198 +++++++++++++++++++
 tb/tb_qea_host_loader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qea_loader_pkg.sv
// rtl/qea_loader_pkg.sv - shared types, default widths and row-count helper for the QEA host loader
package qea_loader_pkg;

    localparam int QEA_PE_NUM_WIDTH            = 2;
    localparam int QEA_PE_NUM                  = 4;
    localparam int QEA_STATE_DATA_WIDTH        = 64;
    localparam int QEA_STATE_ADDR_WIDTH        = 16;
    localparam int QEA_GATE_CONTEXT_DATA_WIDTH = 64;
    localparam int QEA_GATE_CONTEXT_ADDR_WIDTH = 16;
    localparam int QEA_MAX_QBIT_WIDTH          = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CTX   = 3'd1,
        S_ST    = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_RD    = 3'd5
    } loader_state_e;

    // Index of the last state row for a job: 2**(qbit_num-pe_num_width)-1,
    // or 0 when the whole state fits in one row. The shift is clamped so the
    // result saturates at the row address width instead of overflowing.
    function automatic logic [31:0] rows_last_idx(input int qbit_num,
                                                  input int pe_num_width,
                                                  input int addr_width);
        int shift;
        int cap;
        if (qbit_num <= pe_num_width) begin
            return 32'd0;
        end
        shift = qbit_num - pe_num_width;
        cap   = (addr_width < 31) ? addr_width : 31;
        if (shift > cap) begin
            shift = cap;
        end
        return (32'd1 << shift) - 32'd1;
    endfunction

endpackage

// File: rtl/qea_rd_skid.sv
// rtl/qea_rd_skid.sv - one-entry output register with valid/ready for the state readback path
//  in_valid/in_data   : captured RAM read data (never presented while the entry is full)
//  out_valid/out_data : held stable until out_ready
module qea_rd_skid #(
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/qea_host_loader.sv
// rtl/qea_host_loader.sv - loads context words and state rows into the QEA, runs it, streams results back
//  cmd  : i_cmd_valid/o_cmd_ready, i_cmd_qbit_num, i_cmd_ins_num
//  ctx  : i_ctx_valid/o_ctx_ready/i_ctx_data      -> o_qea_ctx_{en,wea,addr,data}
//  st   : i_st_valid/o_st_ready/i_st_data         -> o_qea_state_{ena,wea,addra,dina}
//  rd   : o_rd_valid/i_rd_ready/o_rd_data         <- i_qea_state_dout (one cycle read latency)
//  ctrl : o_qea_start, o_qea_qbit_num, i_qea_complete, o_busy
//  QEA_LOADER_CYCLE_COUNT_EN adds o_exec_cycles (RUN cycles of the last job, saturating).
module qea_host_loader
    import qea_loader_pkg::*;
#(
    parameter int PE_NUM_WIDTH            = QEA_PE_NUM_WIDTH,
    parameter int PE_NUM                  = QEA_PE_NUM,
    parameter int STATE_DATA_WIDTH        = QEA_STATE_DATA_WIDTH,
    parameter int STATE_ADDR_WIDTH        = QEA_STATE_ADDR_WIDTH,
    parameter int GATE_CONTEXT_DATA_WIDTH = QEA_GATE_CONTEXT_DATA_WIDTH,
    parameter int GATE_CONTEXT_ADDR_WIDTH = QEA_GATE_CONTEXT_ADDR_WIDTH,
    parameter int MAX_QBIT_WIDTH          = QEA_MAX_QBIT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_cmd_valid,
    output logic                                 o_cmd_ready,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_cmd_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_cmd_ins_num,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    input  logic                                 i_st_valid,
    output logic                                 o_st_ready,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_st_data,
    output logic                                 o_rd_valid,
    input  logic                                 i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
    output logic                                 o_qea_ctx_en,
    output logic                                 o_qea_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
    output logic [PE_NUM-1:0]                    o_qea_state_ena,
    output logic [PE_NUM-1:0]                    o_qea_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
    output logic                                 o_busy
`ifdef QEA_LOADER_CYCLE_COUNT_EN
    ,
    output logic [31:0]                          o_exec_cycles
`endif
);

    localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;

    loader_state_e state_q, state_d;

    logic [MAX_QBIT_WIDTH-1:0]          qbit_q;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_cnt;
    logic [STATE_ADDR_WIDTH-1:0]        row_cnt;
    logic [STATE_ADDR_WIDTH-1:0]        rows_last;
    logic                               run_first_q;
    logic                               rd_req_q;
    logic                               rd_pend_q;

    logic cmd_fire, ctx_fire, ctx_last, st_fire, st_last;
    logic run_done, rd_fire, rd_last, rd_issue;

    assign rows_last = STATE_ADDR_WIDTH'(rows_last_idx(int'(qbit_q), PE_NUM_WIDTH, STATE_ADDR_WIDTH));

    assign o_cmd_ready    = (state_q == S_IDLE);
    assign o_busy         = (state_q != S_IDLE);
    assign o_ctx_ready    = (state_q == S_CTX);
    assign o_st_ready     = (state_q == S_ST);
    assign o_qea_start    = (state_q == S_START);
    assign o_qea_qbit_num = o_busy ? qbit_q : '0;

    assign cmd_fire = i_cmd_valid & o_cmd_ready;
    assign ctx_fire = i_ctx_valid & o_ctx_ready;
    assign ctx_last = ctx_fire && (ctx_cnt == ins_q - GATE_CONTEXT_ADDR_WIDTH'(1));
    assign st_fire  = i_st_valid & o_st_ready;
    assign st_last  = st_fire && (row_cnt == rows_last);
    // Complete is ignored on the first RUN cycle: the QEA may still show the
    // previous job's completion right after the start pulse.
    assign run_done = (state_q == S_RUN) && !run_first_q && i_qea_complete;
    assign rd_fire  = (state_q == S_RD) && o_rd_valid && i_rd_ready;
    assign rd_last  = rd_fire && (row_cnt == rows_last);
    // Only one read is ever outstanding: the next one leaves on the transfer.
    assign rd_issue = run_done || (rd_fire && !rd_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_fire) state_d = (i_cmd_ins_num == '0) ? S_ST : S_CTX;
            S_CTX:   if (ctx_last) state_d = S_ST;
            S_ST:    if (st_last) state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN:   if (run_done) state_d = S_RD;
            S_RD:    if (rd_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qbit_q            <= '0;
            ins_q             <= '0;
            ctx_cnt           <= '0;
            row_cnt           <= '0;
            run_first_q       <= 1'b0;
            rd_req_q          <= 1'b0;
            rd_pend_q         <= 1'b0;
            o_qea_ctx_en      <= 1'b0;
            o_qea_ctx_wea     <= 1'b0;
            o_qea_ctx_addr    <= '0;
            o_qea_ctx_data    <= '0;
            o_qea_state_ena   <= '0;
            o_qea_state_wea   <= '0;
            o_qea_state_addra <= '0;
            o_qea_state_dina  <= '0;
        end else begin
            o_qea_ctx_en    <= 1'b0;
            o_qea_ctx_wea   <= 1'b0;
            o_qea_state_ena <= '0;
            o_qea_state_wea <= '0;
            rd_req_q        <= 1'b0;
            // RAM data appears the cycle after the read strobe is visible.
            rd_pend_q       <= rd_req_q;
            run_first_q     <= (state_q == S_START);

            if (cmd_fire) begin
                qbit_q  <= i_cmd_qbit_num;
                ins_q   <= i_cmd_ins_num;
                ctx_cnt <= '0;
                row_cnt <= '0;
            end

            if (ctx_fire) begin
                o_qea_ctx_en   <= 1'b1;
                o_qea_ctx_wea  <= 1'b1;
                o_qea_ctx_addr <= ctx_cnt;
                o_qea_ctx_data <= i_ctx_data;
                ctx_cnt        <= ctx_cnt + GATE_CONTEXT_ADDR_WIDTH'(1);
            end

            if (st_fire) begin
                o_qea_state_ena   <= '1;
                o_qea_state_wea   <= '1;
                o_qea_state_addra <= row_cnt;
                o_qea_state_dina  <= i_st_data;
                row_cnt           <= st_last ? '0 : row_cnt + STATE_ADDR_WIDTH'(1);
            end

            if (rd_issue) begin
                o_qea_state_ena   <= '1;
                o_qea_state_addra <= run_done ? '0 : row_cnt + STATE_ADDR_WIDTH'(1);
                rd_req_q          <= 1'b1;
            end

            if (rd_fire) begin
                row_cnt <= rd_last ? '0 : row_cnt + STATE_ADDR_WIDTH'(1);
            end
        end
    end

    qea_rd_skid #(
        .DATA_WIDTH(ROW_W)
    ) u_rd_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd_pend_q),
        .in_data  (i_qea_state_dout),
        .out_valid(o_rd_valid),
        .out_ready(i_rd_ready),
        .out_data (o_rd_data)
    );

`ifdef QEA_LOADER_CYCLE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_exec_cycles <= '0;
        end else if (state_q == S_START) begin
            o_exec_cycles <= '0;
        end else if ((state_q == S_RUN) && (o_exec_cycles != 32'hFFFF_FFFF)) begin
            o_exec_cycles <= o_exec_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qea_host_loader.sv
// tb/tb_qea_host_loader.sv - self-checking bench for qea_host_loader with a QEA RAM/complete stub
module tb_qea_host_loader;

    localparam int RW = 256;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_cmd_valid = 1'b0;
    logic           o_cmd_ready;
    logic [5:0]     i_cmd_qbit_num = '0;
    logic [15:0]    i_cmd_ins_num = '0;
    logic           i_ctx_valid = 1'b0;
    logic           o_ctx_ready;
    logic [63:0]    i_ctx_data = '0;
    logic           i_st_valid = 1'b0;
    logic           o_st_ready;
    logic [RW-1:0]  i_st_data = '0;
    logic           o_rd_valid;
    logic           i_rd_ready = 1'b1;
    logic [RW-1:0]  o_rd_data;
    logic           o_qea_start;
    logic [5:0]     o_qea_qbit_num;
    logic           o_qea_ctx_en;
    logic           o_qea_ctx_wea;
    logic [15:0]    o_qea_ctx_addr;
    logic [63:0]    o_qea_ctx_data;
    logic [3:0]     o_qea_state_ena;
    logic [3:0]     o_qea_state_wea;
    logic [15:0]    o_qea_state_addra;
    logic [RW-1:0]  o_qea_state_dina;
    logic           i_qea_complete;
    logic [RW-1:0]  i_qea_state_dout;
    logic           o_busy;
`ifdef QEA_LOADER_CYCLE_COUNT_EN
    logic [31:0]    o_exec_cycles;
`endif

    always #5 clk = ~clk;

    qea_host_loader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_cmd_valid      (i_cmd_valid),
        .o_cmd_ready      (o_cmd_ready),
        .i_cmd_qbit_num   (i_cmd_qbit_num),
        .i_cmd_ins_num    (i_cmd_ins_num),
        .i_ctx_valid      (i_ctx_valid),
        .o_ctx_ready      (o_ctx_ready),
        .i_ctx_data       (i_ctx_data),
        .i_st_valid       (i_st_valid),
        .o_st_ready       (o_st_ready),
        .i_st_data        (i_st_data),
        .o_rd_valid       (o_rd_valid),
        .i_rd_ready       (i_rd_ready),
        .o_rd_data        (o_rd_data),
        .o_qea_start      (o_qea_start),
        .o_qea_qbit_num   (o_qea_qbit_num),
        .o_qea_ctx_en     (o_qea_ctx_en),
        .o_qea_ctx_wea    (o_qea_ctx_wea),
        .o_qea_ctx_addr   (o_qea_ctx_addr),
        .o_qea_ctx_data   (o_qea_ctx_data),
        .o_qea_state_ena  (o_qea_state_ena),
        .o_qea_state_wea  (o_qea_state_wea),
        .o_qea_state_addra(o_qea_state_addra),
        .o_qea_state_dina (o_qea_state_dina),
        .i_qea_complete   (i_qea_complete),
        .i_qea_state_dout (i_qea_state_dout),
        .o_busy           (o_busy)
`ifdef QEA_LOADER_CYCLE_COUNT_EN
        ,
        .o_exec_cycles    (o_exec_cycles)
`endif
    );

    int nvec = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        nvec++;
        errs++;
        $display("FAIL %s: event occurred, required none", nm);
    endtask

    // QEA stub: single-port state RAM (read-first, 1-cycle latency) and a
    // completion that rises run_len cycles into RUN and stays up. On the
    // first complete cycle every row is inverted, standing in for the job.
    logic [RW-1:0] smem [0:63];
    logic [RW-1:0] sdout;
    int            run_cnt = 0;
    int            run_len = 4;
    logic          running = 1'b0;
    logic          transformed = 1'b0;

    assign i_qea_state_dout = sdout;
    assign i_qea_complete   = running && (run_cnt >= run_len - 1);

    always @(posedge clk) begin
        if (o_qea_state_ena == 4'hF) begin
            if (o_qea_state_wea == 4'hF) smem[o_qea_state_addra[5:0]] <= o_qea_state_dina;
            sdout <= smem[o_qea_state_addra[5:0]];
        end
        if (o_qea_start) begin
            running     <= 1'b1;
            run_cnt     <= 0;
            transformed <= 1'b0;
        end else if (running) begin
            run_cnt <= run_cnt + 1;
            if (i_qea_complete && !transformed) begin
                for (int r = 0; r < 64; r++) smem[r] <= ~smem[r];
                transformed <= 1'b1;
            end
        end
    end

    int stall_pct = 0;
    always @(posedge clk) begin
        #1;
        i_rd_ready = ($urandom_range(0, 99) >= stall_pct);
    end

    // Scoreboard
    typedef struct packed { logic [15:0] a; logic [63:0] d; } ctx_e_t;
    typedef struct packed { logic [15:0] a; logic [RW-1:0] d; } st_e_t;
    ctx_e_t        ctx_q [$];
    st_e_t         st_q  [$];
    logic [RW-1:0] rd_q  [$];

    int ctx_wr_cnt = 0, st_wr_cnt = 0, rd_xfer_cnt = 0, start_cnt = 0;
    int cur_rows = 0, cur_qbit = 0;
    logic          stalled_prev = 1'b0;
    logic [RW-1:0] prev_data = '0;

    always @(negedge clk) begin : monitor
        ctx_e_t ce;
        st_e_t  se;
        logic [RW-1:0] re;
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (o_qea_ctx_en) begin
                ctx_wr_cnt++;
                if (ctx_q.size() == 0) fail_now("ctx_unexpected_write");
                else begin
                    ce = ctx_q.pop_front();
                    chk("ctx_wea", RW'(o_qea_ctx_wea), RW'(1));
                    chk("ctx_addr", RW'(o_qea_ctx_addr), RW'(ce.a));
                    chk("ctx_data", RW'(o_qea_ctx_data), RW'(ce.d));
                end
            end
            if ((o_qea_state_ena == 4'hF) && (o_qea_state_wea == 4'hF)) begin
                st_wr_cnt++;
                if (st_q.size() == 0) fail_now("st_unexpected_write");
                else begin
                    se = st_q.pop_front();
                    chk("st_addr", RW'(o_qea_state_addra), RW'(se.a));
                    chk("st_data", o_qea_state_dina, se.d);
                end
            end
            if (o_qea_start) begin
                start_cnt++;
                chk("start_after_all_rows", RW'(st_wr_cnt), RW'(cur_rows));
                chk("start_qbit_num", RW'(o_qea_qbit_num), RW'(cur_qbit));
            end
            if (stalled_prev) begin
                chk("rd_valid_held", RW'(o_rd_valid), RW'(1));
                chk("rd_data_stable", o_rd_data, prev_data);
            end
            if (o_rd_valid && i_rd_ready) begin
                rd_xfer_cnt++;
                if (rd_q.size() == 0) fail_now("rd_unexpected_row");
                else begin
                    re = rd_q.pop_front();
                    chk("rd_data", o_rd_data, re);
                end
            end
            stalled_prev = o_rd_valid && !i_rd_ready;
            prev_data    = o_rd_data;
        end
    end

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic wait_ready(input bit is_ctx, input string nm);
        int t = 0;
        while (1) begin
            @(negedge clk);
            if (is_ctx ? o_ctx_ready : o_st_ready) break;
            if (++t > 300) begin
                fail_now(nm);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int qbit, input int ins);
        @(posedge clk);
        #1;
        i_cmd_valid    = 1'b1;
        i_cmd_qbit_num = 6'(qbit);
        i_cmd_ins_num  = 16'(ins);
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic send_ctx(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < gap) begin
                i_ctx_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            i_ctx_valid = 1'b1;
            i_ctx_data  = {$urandom(), $urandom()};
            ctx_q.push_back({16'(i), i_ctx_data});
            wait_ready(1'b1, "ctx_ready_timeout");
        end
        i_ctx_valid = 1'b0;
    endtask

    task automatic send_rows(input int n, input int gap, input bit fixed);
        logic [RW-1:0] row;
        for (int r = 0; r < n; r++) begin
            while ($urandom_range(0, 99) < gap) begin
                i_st_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            if (fixed) row = (r == 0) ? {64'h40000000_00000000, 192'h0} : '0;
            else       row = rnd_row();
            i_st_valid = 1'b1;
            i_st_data  = row;
            st_q.push_back({16'(r), row});
            rd_q.push_back(~row);
            wait_ready(1'b0, "st_ready_timeout");
        end
        i_st_valid = 1'b0;
    endtask

    typedef struct {
        int qbit;
        int ins;
        int gap;
        int stall;
        int run;
        bit fixed_row0;
        bit poke;
        int exp_rows;
    } job_t;

    task automatic run_job(input job_t j);
        int t;
        cur_rows    = j.exp_rows;
        cur_qbit    = j.qbit;
        stall_pct   = j.stall;
        run_len     = j.run;
        ctx_wr_cnt  = 0;
        st_wr_cnt   = 0;
        rd_xfer_cnt = 0;
        start_cnt   = 0;
        @(negedge clk);
        chk("idle_cmd_ready", RW'(o_cmd_ready), RW'(1));
        send_cmd(j.qbit, j.ins);
        send_ctx(j.ins, j.gap);
        send_rows(j.exp_rows, j.gap, j.fixed_row0);
        if (j.poke) begin
            t = 0;
            while (start_cnt == 0 && t < 100) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
            #1;
            i_cmd_valid    = 1'b1;
            i_cmd_qbit_num = 6'd9;
            i_cmd_ins_num  = 16'd5;
            @(negedge clk);
            chk("cmd_ready_in_run", RW'(o_cmd_ready), RW'(0));
            chk("busy_in_run", RW'(o_busy), RW'(1));
            chk("qbit_held_in_run", RW'(o_qea_qbit_num), RW'(j.qbit));
            @(posedge clk);
            #1;
            i_cmd_valid = 1'b0;
        end
        t = 0;
        while (1) begin
            @(negedge clk);
            if (!o_busy) break;
            if (++t > 5000) begin
                fail_now("job_done_timeout");
                break;
            end
        end
        chk("ctx_write_count", RW'(ctx_wr_cnt), RW'(j.ins));
        chk("st_write_count", RW'(st_wr_cnt), RW'(j.exp_rows));
        chk("rd_row_count", RW'(rd_xfer_cnt), RW'(j.exp_rows));
        chk("start_pulses", RW'(start_cnt), RW'(1));
        chk("queues_drained", RW'(ctx_q.size() + st_q.size() + rd_q.size()), RW'(0));
        chk("cmd_ready_after_job", RW'(o_cmd_ready), RW'(1));
`ifdef QEA_LOADER_CYCLE_COUNT_EN
        chk("exec_cycles", RW'(o_exec_cycles), RW'((j.run < 2) ? 2 : j.run));
`endif
    endtask

    job_t jobs [5];

    initial begin
        jobs[0] = '{qbit: 4, ins: 151, gap: 0,  stall: 0,  run: 37, fixed_row0: 1'b1, poke: 1'b0, exp_rows: 4};
        jobs[1] = '{qbit: 2, ins: 0,   gap: 0,  stall: 0,  run: 3,  fixed_row0: 1'b0, poke: 1'b0, exp_rows: 1};
        jobs[2] = '{qbit: 5, ins: 20,  gap: 30, stall: 40, run: 6,  fixed_row0: 1'b0, poke: 1'b0, exp_rows: 8};
        jobs[3] = '{qbit: 1, ins: 3,   gap: 50, stall: 60, run: 1,  fixed_row0: 1'b0, poke: 1'b0, exp_rows: 1};
        jobs[4] = '{qbit: 3, ins: 7,   gap: 0,  stall: 0,  run: 20, fixed_row0: 1'b0, poke: 1'b1, exp_rows: 2};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", RW'(o_cmd_ready), RW'(1));
        chk("rst_busy", RW'(o_busy), RW'(0));
        chk("rst_start", RW'(o_qea_start), RW'(0));
        chk("rst_ctx_en", RW'(o_qea_ctx_en), RW'(0));
        chk("rst_state_ena", RW'(o_qea_state_ena), RW'(0));
        chk("rst_rd_valid", RW'(o_rd_valid), RW'(0));
        chk("rst_in_ready", RW'({o_ctx_ready, o_st_ready}), RW'(0));
        chk("rst_qbit_num", RW'(o_qea_qbit_num), RW'(0));

        for (int k = 0; k < 2; k++) run_job(jobs[k]);

        // Reset in the middle of state loading.
        cur_rows = 2;
        cur_qbit = 3;
        send_cmd(3, 2);
        send_ctx(2, 0);
        send_rows(1, 0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctx_en", RW'(o_qea_ctx_en), RW'(0));
        chk("mid_rst_state_ena", RW'(o_qea_state_ena), RW'(0));
        chk("mid_rst_start", RW'(o_qea_start), RW'(0));
        chk("mid_rst_busy", RW'(o_busy), RW'(0));
        chk("mid_rst_st_ready", RW'(o_st_ready), RW'(0));
        ctx_q.delete();
        st_q.delete();
        rd_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", RW'(o_cmd_ready), RW'(1));
        chk("post_rst_busy", RW'(o_busy), RW'(0));
        chk("post_rst_strobes", RW'({o_qea_ctx_en, o_qea_state_ena, o_qea_start}), RW'(0));

        for (int k = 2; k < 5; k++) run_job(jobs[k]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
